// File: rtl/dp_cfg_pkg.sv
// Shared types and the boot configuration table for dp_timing_cfg_loader.
// Contents:
//   state_e      loader FSM states
//   DP_REG_*     dp_test_top register offsets
//   cfg_entry_t  one table record {addr, data}
//   CFG_TABLE    720p60 timing/pattern set, bracketed by core reset assert/release
//   cfg_entry()  bounded table lookup (returns zero outside the table)
package dp_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitB,
    StNext,
    StDoneSt,
    StErr
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [15:0] DP_REG_CTRL      = 16'h0000;
  localparam logic [15:0] DP_REG_VTOTAL    = 16'h0004;
  localparam logic [15:0] DP_REG_HTOTAL    = 16'h0008;
  localparam logic [15:0] DP_REG_VBLANK    = 16'h000C;
  localparam logic [15:0] DP_REG_HBLANK    = 16'h0010;
  localparam logic [15:0] DP_REG_VS_START  = 16'h0014;
  localparam logic [15:0] DP_REG_VS_END    = 16'h0018;
  localparam logic [15:0] DP_REG_VS_HSTART = 16'h001C;
  localparam logic [15:0] DP_REG_VS_HEND   = 16'h0020;
  localparam logic [15:0] DP_REG_HS_VSTART = 16'h0024;
  localparam logic [15:0] DP_REG_HS_VEND   = 16'h0028;
  localparam logic [15:0] DP_REG_HS_START  = 16'h002C;
  localparam logic [15:0] DP_REG_HS_END    = 16'h0030;
  localparam logic [15:0] DP_REG_PAT_R     = 16'h0034;
  localparam logic [15:0] DP_REG_PAT_G     = 16'h0038;
  localparam logic [15:0] DP_REG_PAT_B     = 16'h003C;
  localparam logic [15:0] DP_REG_PAT_ALT   = 16'h0040;
  localparam logic [15:0] DP_REG_PAT_SEL   = 16'h0044;
  localparam logic [15:0] DP_REG_PAT_CTRL  = 16'h0048;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } cfg_entry_t;

  localparam int unsigned CFG_N = 20;

  // Entry 0 holds the core in reset while timing is written; the last entry releases it.
  localparam cfg_entry_t CFG_TABLE [CFG_N] = '{
    '{DP_REG_CTRL,      32'd1},
    '{DP_REG_VTOTAL,    32'd750},
    '{DP_REG_HTOTAL,    32'd1648},
    '{DP_REG_VBLANK,    32'd30},
    '{DP_REG_HBLANK,    32'd368},
    '{DP_REG_VS_START,  32'd3},
    '{DP_REG_VS_END,    32'd8},
    '{DP_REG_VS_HSTART, 32'd0},
    '{DP_REG_VS_HEND,   32'd1648},
    '{DP_REG_HS_VSTART, 32'd0},
    '{DP_REG_HS_VEND,   32'd750},
    '{DP_REG_HS_START,  32'd72},
    '{DP_REG_HS_END,    32'd152},
    '{DP_REG_PAT_R,     32'h0000_00F0},
    '{DP_REG_PAT_G,     32'h0000_000F},
    '{DP_REG_PAT_B,     32'h0000_00AA},
    '{DP_REG_PAT_ALT,   32'h0000_0055},
    '{DP_REG_PAT_SEL,   32'd8},
    '{DP_REG_PAT_CTRL,  32'd0},
    '{DP_REG_CTRL,      32'd0}
  };

  function automatic cfg_entry_t cfg_entry(input logic [4:0] idx);
    cfg_entry_t e;
    e = '0;
    if (int'(idx) < int'(CFG_N)) begin
      e = CFG_TABLE[idx];
    end
    return e;
  endfunction

endpackage

// File: rtl/dp_cfg_rom.sv
// Combinational index -> configuration entry lookup. Replace this module to
// boot a different video mode.
// Ports:
//   idx_i    table index
//   entry_o  {addr, data} for that index (zero beyond the table)
module dp_cfg_rom
  import dp_cfg_pkg::*;
(
  input  logic [4:0] idx_i,
  output cfg_entry_t entry_o
);

  always_comb begin
    entry_o = cfg_entry(idx_i);
  end

endmodule

// File: rtl/dp_timing_cfg_loader.sv
// AXI4-Lite write-only master that replays the boot configuration table into
// the dp_test_top register bank after a START pulse.
// Ports:
//   ACLK, ARESET       clock, asynchronous active-high reset
//   START              one-cycle pulse, honoured only when idle
//   BUSY/DONE/ERROR    status; DONE and ERROR are sticky until the next START
//   ERR_IDX            table index of the failing write
//   M_AXI_AW*/W*/B*    AXI4-Lite write channels (no read channels)
module dp_timing_cfg_loader
  import dp_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_ENTRIES = 20,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [4:0]        ERR_IDX,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [3:0]        M_AXI_AWCACHE,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  input  logic [1:0]        M_AXI_BRESP
);

  localparam int unsigned TmoW = $clog2(TIMEOUT);

  state_e            state_q;
  logic [4:0]        idx_q;
  logic [4:0]        err_idx_q;
  logic [TmoW-1:0]   tmo_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              awvalid_q, wvalid_q, bready_q;
  logic              aw_done_q, w_done_q, b_done_q;
  logic [1:0]        bresp_q;
  logic              busy_q, done_q, error_q;

  logic [4:0]  rom_idx;
  cfg_entry_t  rom_entry;

  logic       aw_hs, w_hs, b_hs;
  logic       aw_all, w_all, b_all;
  logic       tmo_hit;
  logic [1:0] resp_now;

  dp_cfg_rom u_rom (
    .idx_i   (rom_idx),
    .entry_o (rom_entry)
  );

  always_comb begin
    aw_hs    = awvalid_q & M_AXI_AWREADY;
    w_hs     = wvalid_q & M_AXI_WREADY;
    b_hs     = bready_q & M_AXI_BVALID;
    aw_all   = aw_done_q | aw_hs;
    w_all    = w_done_q | w_hs;
    // B may complete together with (or, from a sloppy slave, before) the last of AW/W.
    b_all    = b_done_q | b_hs;
    resp_now = b_hs ? M_AXI_BRESP : bresp_q;
    tmo_hit  = (tmo_q == TmoW'(TIMEOUT - 1));
    // The entry is loaded on the edge leaving IDLE (entry 0) or NEXT (entry idx+1).
    rom_idx  = (state_q == StNext) ? (idx_q + 5'd1) : 5'd0;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      err_idx_q <= '0;
      tmo_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (START) begin
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            awaddr_q  <= ADDR_W'(rom_entry.addr);
            wdata_q   <= DATA_W'(rom_entry.data);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            tmo_q     <= '0;
            state_q   <= StIssue;
          end
        end

        StIssue: begin
          if (tmo_hit) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            error_q   <= 1'b1;
            busy_q    <= 1'b0;
            err_idx_q <= idx_q;
            state_q   <= StErr;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
            if (aw_hs) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (w_hs) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
            if (b_hs) begin
              bready_q <= 1'b0;
              b_done_q <= 1'b1;
              bresp_q  <= M_AXI_BRESP;
            end
            if (aw_all && w_all) begin
              if (!b_all) begin
                state_q <= StWaitB;
              end else if (resp_now == RESP_OKAY) begin
                state_q <= StNext;
              end else begin
                bready_q  <= 1'b0;
                error_q   <= 1'b1;
                busy_q    <= 1'b0;
                err_idx_q <= idx_q;
                state_q   <= StErr;
              end
            end
          end
        end

        StWaitB: begin
          if (tmo_hit) begin
            bready_q  <= 1'b0;
            error_q   <= 1'b1;
            busy_q    <= 1'b0;
            err_idx_q <= idx_q;
            state_q   <= StErr;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
            if (b_hs) begin
              bready_q <= 1'b0;
              bresp_q  <= M_AXI_BRESP;
              if (M_AXI_BRESP == RESP_OKAY) begin
                state_q <= StNext;
              end else begin
                error_q   <= 1'b1;
                busy_q    <= 1'b0;
                err_idx_q <= idx_q;
                state_q   <= StErr;
              end
            end
          end
        end

        StNext: begin
          if (idx_q == 5'(N_ENTRIES - 1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDoneSt;
          end else begin
            idx_q     <= idx_q + 5'd1;
            awaddr_q  <= ADDR_W'(rom_entry.addr);
            wdata_q   <= DATA_W'(rom_entry.data);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            tmo_q     <= '0;
            state_q   <= StIssue;
          end
        end

        StDoneSt: state_q <= StIdle;

        // ERROR stays set; the release write is deliberately skipped so the core stays in reset.
        StErr: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERROR         = error_q;
  assign ERR_IDX       = err_idx_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule
